// File: rtl/jtag_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_pkg
//  Description : Shared types and constants for the oversampled JTAG TAP:
//                16-state TAP enum, instruction opcodes, IR capture pattern
//                and the IEEE 1149.1 next-state function.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    localparam logic [4:0] c_IDCODE     = 5'h01;
    localparam logic [4:0] c_DR_ACCESS  = 5'h11;
    localparam logic [4:0] c_BYPASS     = 5'h1F;
    // Low bits loaded into the IR in Capture-IR; upper bits are zero
    localparam logic [1:0] c_IR_CAPTURE = 2'b01;

    // Standard TAP controller transition taken on a TCK rising edge
    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_sync_edge
//  Description : Multi-flop synchronizer for asynchronous JTAG pins. One lane
//                (edge_in) additionally gets a history flop for rise/fall
//                detection; the WIDTH-bit sync_in bus is synchronized only.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_sync_edge #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             edge_in,
    output logic             edge_rise,
    output logic             edge_fall,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [SYNC_STAGES-1:0]            r_edge_sync;
    logic                              r_edge_hist;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_data_sync;
    logic                              w_edge_synced;

    // Synchronizer chains: new sample enters stage 0, oldest stage is the output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_edge_sync <= '0;
            r_data_sync <= '0;
        end else begin
            r_edge_sync <= {r_edge_sync[SYNC_STAGES-2:0], edge_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], sync_in};
        end
    end

    // One history flop so a rise and a fall can never be seen in the same clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_edge_hist <= 1'b0;
        end else begin
            r_edge_hist <= w_edge_synced;
        end
    end

    assign w_edge_synced = r_edge_sync[SYNC_STAGES-1];
    assign edge_rise     =  w_edge_synced & ~r_edge_hist;
    assign edge_fall     = ~w_edge_synced &  r_edge_hist;
    assign sync_out      = r_data_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_sampled
//  Description : IEEE 1149.1 TAP that oversamples TCK/TMS/TDI/TRSTn on the
//                system clock. Provides IDCODE, BYPASS and a DR_ACCESS data
//                register for the debug-module interface.
//                Optional macro JTAG_TAP_TCK_CHECK_EN builds a TCK-rate
//                checker driving the sticky tck_too_fast flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_sampled
    import jtag_tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter int          DR_WIDTH     = 41,
    parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    output logic [IR_WIDTH-1:0] ir_o,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic                dr_update_valid,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic                tck_too_fast
);

    // DR shift register must hold the 32-bit IDCODE as well as DR_ACCESS
    localparam int c_DR_SR_W = (DR_WIDTH > 32) ? DR_WIDTH : 32;
    localparam int c_IDX_W   = $clog2(c_DR_SR_W);

    localparam logic [IR_WIDTH-1:0] c_IR_IDCODE    = IR_WIDTH'(c_IDCODE);
    localparam logic [IR_WIDTH-1:0] c_IR_DR_ACCESS = IR_WIDTH'(c_DR_ACCESS);
    localparam logic [IR_WIDTH-1:0] c_IR_BYPASS    = IR_WIDTH'(c_BYPASS);

    tap_state_e             r_state;
    tap_state_e             w_state_next;
    logic [IR_WIDTH-1:0]    r_ir;
    logic [IR_WIDTH-1:0]    r_ir_shift;
    logic [c_DR_SR_W-1:0]   r_dr_shift;
    logic [c_DR_SR_W-1:0]   w_dr_shifted;
    logic [c_DR_SR_W-1:0]   w_dr_capture;
    logic [c_IDX_W-1:0]     w_dr_msb;
    logic                   r_tdo_data;
    logic                   r_tdo_driven;
    logic                   r_upd_valid;
    logic [DR_WIDTH-1:0]    r_upd_data;
    logic                   w_tck_rise;
    logic                   w_tck_fall;
    logic                   w_tms_s;
    logic                   w_tdi_s;
    logic                   w_trst_n_s;
    logic                   w_step;
    logic [2:0]             w_pins_s;

    jtag_sync_edge #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .edge_in   (jtag_TCK),
        .edge_rise (w_tck_rise),
        .edge_fall (w_tck_fall),
        .sync_in   ({jtag_TRSTn, jtag_TDI, jtag_TMS}),
        .sync_out  (w_pins_s)
    );

    assign w_tms_s    = w_pins_s[0];
    assign w_tdi_s    = w_pins_s[1];
    assign w_trst_n_s = w_pins_s[2];
    // Rising-edge actions are suppressed while TRSTn holds the TAP in reset
    assign w_step     = w_tck_rise & w_trst_n_s;

    // TAP state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: TRSTn dominates, otherwise advance on each TCK rise
    always_comb begin
        w_state_next = r_state;
        if (!w_trst_n_s) begin
            w_state_next = TEST_LOGIC_RESET;
        end else if (w_tck_rise) begin
            w_state_next = tap_next(r_state, w_tms_s);
        end
    end

    // DR length (as MSB index) and capture value selected by the current IR
    always_comb begin
        w_dr_msb     = '0;
        w_dr_capture = '0;
        case (r_ir)
            c_IR_IDCODE: begin
                w_dr_msb     = c_IDX_W'(31);
                w_dr_capture = c_DR_SR_W'(IDCODE_VALUE);
            end
            c_IR_DR_ACCESS: begin
                w_dr_msb     = c_IDX_W'(DR_WIDTH - 1);
                w_dr_capture = c_DR_SR_W'(dr_capture_data);
            end
            c_IR_BYPASS: begin
                w_dr_msb     = '0;
                w_dr_capture = '0;
            end
            default: begin
                w_dr_msb     = '0;
                w_dr_capture = '0;
            end
        endcase
        // Right shift with TDI entering at the top of the selected length;
        // bits above that length keep shifting but never reach TDO
        w_dr_shifted           = {1'b0, r_dr_shift[c_DR_SR_W-1:1]};
        w_dr_shifted[w_dr_msb] = w_tdi_s;
    end

    // Instruction shift register: capture then shift on TCK rise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir_shift <= '0;
        end else if (w_step) begin
            if (r_state == CAPTURE_IR) begin
                r_ir_shift <= IR_WIDTH'(c_IR_CAPTURE);
            end else if (r_state == SHIFT_IR) begin
                r_ir_shift <= {w_tdi_s, r_ir_shift[IR_WIDTH-1:1]};
            end
        end
    end

    // Data shift register shared by IDCODE, BYPASS and DR_ACCESS
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dr_shift <= '0;
        end else if (w_step) begin
            if (r_state == CAPTURE_DR) begin
                r_dr_shift <= w_dr_capture;
            end else if (r_state == SHIFT_DR) begin
                r_dr_shift <= w_dr_shifted;
            end
        end
    end

    // Current instruction: reloaded with IDCODE whenever the TAP is in reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir <= c_IR_IDCODE;
        end else if (w_state_next == TEST_LOGIC_RESET) begin
            r_ir <= c_IR_IDCODE;
        end else if (w_step && (r_state == UPDATE_IR)) begin
            r_ir <= r_ir_shift;
        end
    end

    // TDO launched on TCK fall from the LSB of the active shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tdo_data   <= 1'b0;
            r_tdo_driven <= 1'b0;
        end else if (w_state_next == TEST_LOGIC_RESET) begin
            r_tdo_data   <= 1'b0;
            r_tdo_driven <= 1'b0;
        end else if (w_tck_fall) begin
            r_tdo_driven <= (r_state == SHIFT_IR) || (r_state == SHIFT_DR);
            if (r_state == SHIFT_IR) begin
                r_tdo_data <= r_ir_shift[0];
            end else if (r_state == SHIFT_DR) begin
                r_tdo_data <= r_dr_shift[0];
            end else begin
                r_tdo_data <= 1'b0;
            end
        end
    end

    // DR_ACCESS update: single-clock valid pulse, data held until next update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_upd_valid <= 1'b0;
            r_upd_data  <= '0;
        end else begin
            r_upd_valid <= 1'b0;
            if (w_step && (r_state == UPDATE_DR) && (r_ir == c_IR_DR_ACCESS)) begin
                r_upd_valid <= 1'b1;
                r_upd_data  <= r_dr_shift[DR_WIDTH-1:0];
            end
        end
    end

`ifdef JTAG_TAP_TCK_CHECK_EN
    localparam int c_MIN_HOLD = SYNC_STAGES + 2;
    localparam int c_CNT_W    = $clog2(c_MIN_HOLD + 1);

    logic [c_CNT_W-1:0] r_hold_cnt;
    logic               r_too_fast;
    logic               w_tck_edge;
    logic               w_edge_early;

    assign w_tck_edge   = w_tck_rise | w_tck_fall;
    assign w_edge_early = w_tck_edge && (r_hold_cnt < c_CNT_W'(c_MIN_HOLD));

    // Clocks since last TCK edge, saturating at the minimum legal hold time
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= c_CNT_W'(c_MIN_HOLD);
            r_too_fast <= 1'b0;
        end else begin
            if (w_edge_early) begin
                r_too_fast <= 1'b1;
            end
            if (w_tck_edge) begin
                r_hold_cnt <= c_CNT_W'(1);
            end else if (r_hold_cnt < c_CNT_W'(c_MIN_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + c_CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only report of each TCK level held too briefly
    always_ff @(posedge clock) begin
        if (!reset && w_edge_early) begin
            $error("jtag_tap_sampled: TCK level held fewer than %0d clocks", c_MIN_HOLD);
        end
    end
`endif

    assign tck_too_fast = r_too_fast;
`else
    assign tck_too_fast = 1'b0;
`endif

    assign ir_o            = r_ir;
    assign jtag_TDO_data   = r_tdo_data;
    assign jtag_TDO_driven = r_tdo_driven;
    assign dr_update_valid = r_upd_valid;
    assign dr_update_data  = r_upd_data;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_tap_sampled
//  Description : Self-checking bench for jtag_tap_sampled: table of IR/DR
//                scans with hand-computed TDO and update expectations, plus
//                directed TMS-reset, TRSTn and async-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_sampled;

    localparam int IR_W = 5;
    localparam int DR_W = 41;

    logic            clock;
    logic            reset;
    logic            jtag_TCK;
    logic            jtag_TMS;
    logic            jtag_TDI;
    logic            jtag_TRSTn;
    logic            jtag_TDO_data;
    logic            jtag_TDO_driven;
    logic [IR_W-1:0] ir_o;
    logic [DR_W-1:0] dr_capture_data;
    logic            dr_update_valid;
    logic [DR_W-1:0] dr_update_data;
    logic            tck_too_fast;

    int checks   = 0;
    int failures = 0;
    int half     = 6;   // clocks per TCK level
    int pulses   = 0;   // clocks seen with dr_update_valid high

    typedef struct {
        logic [4:0]  ir;
        int          len;
        logic [63:0] tdi;
        logic [40:0] cap;
        logic [63:0] exp_tdo;
        bit          upd;
    } vec_t;

    vec_t vecs[6];

    jtag_tap_sampled dut (
        .clock           (clock),
        .reset           (reset),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .ir_o            (ir_o),
        .dr_capture_data (dr_capture_data),
        .dr_update_valid (dr_update_valid),
        .dr_update_data  (dr_update_data),
        .tck_too_fast    (tck_too_fast)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (dr_update_valid === 1'b1) pulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One full TCK period; outputs sampled at the end of the low phase
    task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic drv);
        @(negedge clock);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        @(negedge clock);
        jtag_TCK = 1'b1;
        repeat (half) @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (half) @(negedge clock);
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
    endtask

    // From Run-Test/Idle: full IR or DR scan ending back in Run-Test/Idle
    task automatic scan(input bit is_ir, input int len, input logic [63:0] tdi,
                        output logic [63:0] tdo, output logic [63:0] drv,
                        output logic drv_after);
        logic o, d;
        tdo = '0;
        drv = '0;
        drv_after = 1'b0;
        tck(1'b1, 1'b0, o, d);
        if (is_ir) tck(1'b1, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tdo[0] = o;
        drv[0] = d;
        for (int i = 0; i < len; i++) begin
            tck((i == len - 1), tdi[i], o, d);
            if (i < len - 1) begin
                tdo[i+1] = o;
                drv[i+1] = d;
            end else begin
                drv_after = d;
            end
        end
        tck(1'b1, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
    endtask

    function automatic logic [63:0] mask_of(input int len);
        logic [63:0] m;
        m = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
        return m;
    endfunction

    initial begin
        logic [63:0]     tdo_v, drv_v, m;
        logic            drv_after, o, d;
        logic [DR_W-1:0] model_upd;
        int              p0;

        vecs[0] = '{5'h01, 32, 64'h0,              41'h0,              64'h249511C3,       1'b0};
        vecs[1] = '{5'h11, 41, 64'h0_DEAD_BEEF_1,  41'h1_2345_6789_A,  64'h1_2345_6789_A,  1'b1};
        vecs[2] = '{5'h1F, 8,  64'hA5,             41'h0,              64'h4A,             1'b0};
        vecs[3] = '{5'h11, 41, 64'h0AA_AAAA_AAAA,  41'h1FF_FFFF_FFFF,  64'h1FF_FFFF_FFFF,  1'b1};
        vecs[4] = '{5'h05, 4,  64'hD,              41'h0,              64'hA,              1'b0};
        vecs[5] = '{5'h01, 32, 64'hFFFF_FFFF,      41'h0,              64'h249511C3,       1'b0};

        reset           = 1'b1;
        jtag_TCK        = 1'b0;
        jtag_TMS        = 1'b1;
        jtag_TDI        = 1'b0;
        jtag_TRSTn      = 1'b1;
        dr_capture_data = '0;
        model_upd       = '0;

        // Reset values
        repeat (4) @(negedge clock);
        check("rst_ir",        64'(ir_o), 64'h01);
        check("rst_tdo_data",  64'(jtag_TDO_data), 64'h0);
        check("rst_tdo_drv",   64'(jtag_TDO_driven), 64'h0);
        check("rst_upd_valid", 64'(dr_update_valid), 64'h0);
        check("rst_upd_data",  64'(dr_update_data), 64'h0);
        check("rst_too_fast",  64'(tck_too_fast), 64'h0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 6; i++) tck(1'b1, 1'b0, o, d);
        check("tlr_ir",  64'(ir_o), 64'h01);
        check("tlr_drv", 64'(d), 64'h0);
        tck(1'b0, 1'b0, o, d);

        // Table of IR load + DR scan records
        for (int v = 0; v < 6; v++) begin
            dr_capture_data = vecs[v].cap;
            scan(1'b1, IR_W, 64'(vecs[v].ir), tdo_v, drv_v, drv_after);
            check($sformatf("v%0d_ir_capture", v), tdo_v & mask_of(IR_W), 64'h01);
            check($sformatf("v%0d_ir_o", v), 64'(ir_o), 64'(vecs[v].ir));
            p0 = pulses;
            scan(1'b0, vecs[v].len, vecs[v].tdi, tdo_v, drv_v, drv_after);
            m = mask_of(vecs[v].len);
            if (vecs[v].upd) model_upd = vecs[v].tdi[DR_W-1:0];
            check($sformatf("v%0d_dr_tdo", v), tdo_v & m, vecs[v].exp_tdo);
            check($sformatf("v%0d_dr_drv", v), drv_v & m, m);
            check($sformatf("v%0d_drv_after", v), 64'(drv_after), 64'h0);
            check($sformatf("v%0d_upd_pulses", v), 64'(pulses - p0), vecs[v].upd ? 64'd1 : 64'd0);
            check($sformatf("v%0d_upd_data", v), 64'(dr_update_data), 64'(model_upd));
        end

        // Five TMS=1 edges from Shift-IR reach Test-Logic-Reset
        scan(1'b1, IR_W, 64'h1F, tdo_v, drv_v, drv_after);
        check("tms_pre_ir", 64'(ir_o), 64'h1F);
        tck(1'b1, 1'b0, o, d);
        tck(1'b1, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        check("tms_shift_drv", 64'(d), 64'h1);
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, o, d);
        check("tms_rst_ir",  64'(ir_o), 64'h01);
        check("tms_rst_drv", 64'(d), 64'h0);
        tck(1'b0, 1'b0, o, d);

        // TRSTn asserted in the middle of Shift-DR
        scan(1'b1, IR_W, 64'h11, tdo_v, drv_v, drv_after);
        dr_capture_data = 41'h0_1234_5678_9;
        p0 = pulses;
        tck(1'b1, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        for (int i = 0; i < 3; i++) tck(1'b0, 1'b1, o, d);
        check("trst_pre_drv", 64'(d), 64'h1);
        @(negedge clock);
        jtag_TRSTn = 1'b0;
        repeat (3) @(negedge clock);
        check("trst_ir",  64'(ir_o), 64'h01);
        check("trst_drv", 64'(jtag_TDO_driven), 64'h0);
        tck(1'b0, 1'b1, o, d);
        tck(1'b0, 1'b1, o, d);
        check("trst_hold_ir", 64'(ir_o), 64'h01);
        jtag_TRSTn = 1'b1;
        repeat (4) @(negedge clock);
        check("trst_no_update", 64'(pulses - p0), 64'd0);
        check("trst_upd_data",  64'(dr_update_data), 64'(model_upd));
        tck(1'b0, 1'b0, o, d);
        scan(1'b0, 32, 64'h0, tdo_v, drv_v, drv_after);
        check("trst_idcode", tdo_v & mask_of(32), 64'h249511C3);

        // Asynchronous reset in the middle of Shift-DR
        scan(1'b1, IR_W, 64'h11, tdo_v, drv_v, drv_after);
        p0 = pulses;
        tck(1'b1, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tck(1'b0, 1'b0, o, d);
        tck(1'b0, 1'b1, o, d);
        tck(1'b0, 1'b0, o, d);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("arst_ir",       64'(ir_o), 64'h01);
        check("arst_drv",      64'(jtag_TDO_driven), 64'h0);
        check("arst_upd_data", 64'(dr_update_data), 64'h0);
        model_upd = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("arst_no_update", 64'(pulses - p0), 64'd0);
        tck(1'b0, 1'b0, o, d);
        scan(1'b0, 32, 64'h0, tdo_v, drv_v, drv_after);
        check("arst_idcode", tdo_v & mask_of(32), 64'h249511C3);
        check("too_fast_idle", 64'(tck_too_fast), 64'h0);

`ifdef JTAG_TAP_TCK_CHECK_EN
        half = 50;
        tck(1'b1, 1'b0, o, d);
        tck(1'b1, 1'b0, o, d);
        check("slow_tck_flag", 64'(tck_too_fast), 64'h0);
        half = 2;
        for (int i = 0; i < 3; i++) tck(1'b1, 1'b0, o, d);
        check("fast_tck_flag", 64'(tck_too_fast), 64'h1);
        half = 6;
        repeat (30) @(negedge clock);
        check("fast_tck_sticky", 64'(tck_too_fast), 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
